ser2par8: RTL and testbench

SER2PAR8 -- requirements
Module: ser2par8

---
 rtl/ser2par8_if.sv | 22 ++
 rtl/ser2par8.sv | 132 +++++++++++++
 tb/tb_ser2par8.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ser2par8_if.sv
// Serial-in / parallel-out bus bundle for ser2par8.
// master drives the serial line and bit-sample enable; slave (the deserialiser)
// returns the assembled byte and the one-cycle strobes.
interface ser2par8_if;
   logic       sen;
   logic       sin;
   logic [7:0] dout;
   logic       pl;
   logic       ferr;
   logic       perr;
   logic       busy;

   modport master (
      output sen, sin,
      input  dout, pl, ferr, perr, busy
   );

   modport slave (
      input  sen, sin,
      output dout, pl, ferr, perr, busy
   );
endinterface

// File: rtl/ser2par8.sv
// ser2par8: 8-bit serial-to-parallel receiver with start/stop framing.
// Samples sin only on cycles with sen=1. A good frame loads dout and pulses pl
// for one cycle; a bad stop bit pulses ferr, a parity miss pulses perr.
// Optional feature macro: PARITY_EN (adds the PAR state and an even-parity check).
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | line idle, waiting for a start bit (sin=0)
// DATA  | shifting in the 8 data bits, bit counter tracks position
// PAR   | sampling the even-parity bit (PARITY_EN builds only)
// STOP  | sampling the stop bit, issuing pl / ferr / perr
module ser2par8 #(
   parameter bit MSB_FIRST = 1'b1
) (
   input logic       clk,
   input logic       rst,
   ser2par8_if.slave bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DATA = 2'd1;
`ifdef PARITY_EN
   localparam logic [1:0] S_PAR  = 2'd2;
`endif
   localparam logic [1:0] S_STOP = 2'd3;

   logic [1:0] state_q, state_d;
   logic [2:0] cnt_q,   cnt_d;
   logic [7:0] shreg_q, shreg_d;
   logic [7:0] dout_q,  dout_d;
   logic       pl_q,    pl_d;
   logic       ferr_q,  ferr_d;
`ifdef PARITY_EN
   logic       perr_q,  perr_d;
   logic       pflag_q, pflag_d;
`endif

   // next-state, shift and strobe logic; strobes default low so they last one cycle
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      dout_d  = dout_q;
      pl_d    = 1'b0;
      ferr_d  = 1'b0;
`ifdef PARITY_EN
      perr_d  = 1'b0;
      pflag_d = pflag_q;
`endif
      if (bus.sen) begin
         case (state_q)
            S_IDLE: begin
               if (!bus.sin) begin
                  state_d = S_DATA;
                  cnt_d   = 3'd0;
               end
            end
            S_DATA: begin
               if (MSB_FIRST) shreg_d = {shreg_q[6:0], bus.sin};
               else           shreg_d = {bus.sin, shreg_q[7:1]};
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
`ifdef PARITY_EN
                  state_d = S_PAR;
`else
                  state_d = S_STOP;
`endif
               end
            end
`ifdef PARITY_EN
            S_PAR: begin
               pflag_d = (^shreg_q) ^ bus.sin;
               state_d = S_STOP;
            end
`endif
            S_STOP: begin
               state_d = S_IDLE;
               // a bad stop bit wins over a parity miss
               if (!bus.sin) begin
                  ferr_d = 1'b1;
`ifdef PARITY_EN
               end else if (pflag_q) begin
                  perr_d = 1'b1;
`endif
               end else begin
                  pl_d   = 1'b1;
                  dout_d = shreg_q;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // state registers; reset discards any partial frame without strobing
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 3'd0;
         shreg_q <= 8'h00;
         dout_q  <= 8'h00;
         pl_q    <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef PARITY_EN
         perr_q  <= 1'b0;
         pflag_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         dout_q  <= dout_d;
         pl_q    <= pl_d;
         ferr_q  <= ferr_d;
`ifdef PARITY_EN
         perr_q  <= perr_d;
         pflag_q <= pflag_d;
`endif
      end
   end

   assign bus.dout = dout_q;
   assign bus.pl   = pl_q;
   assign bus.ferr = ferr_q;
`ifdef PARITY_EN
   assign bus.perr = perr_q;
`else
   assign bus.perr = 1'b0;
`endif
   assign bus.busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_ser2par8.sv
// Directed testbench for ser2par8: one MSB-first and one LSB-first instance.
module tb_ser2par8;

`ifdef PARITY_EN
   localparam int FRAME_LEN = 11;
`else
   localparam int FRAME_LEN = 10;
`endif

   typedef struct {
      int         d;
      logic [7:0] bits;     // bits[7] is sent first
      logic       par;
      logic       stop;
      int         period;
      logic [7:0] exp_dout;
      logic       exp_pl;
      logic       exp_ferr;
      logic       exp_perr;
      string      name;
   } vec_t;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   ser2par8_if if0 ();
   ser2par8_if if1 ();

   ser2par8 #(.MSB_FIRST(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
   ser2par8 #(.MSB_FIRST(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(if1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // strobe monitor: counts pulses, remembers pl timing, flags rule violations
   int cyc = 0;
   int pl_cnt0 = 0, fe_cnt0 = 0, pe_cnt0 = 0;
   int pl_cnt1 = 0, fe_cnt1 = 0, pe_cnt1 = 0;
   int last_pl0 = 0, prev_pl0 = 0;
   int viol = 0;
   logic any0_q = 1'b0, any1_q = 1'b0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (if0.pl) begin
         pl_cnt0  <= pl_cnt0 + 1;
         last_pl0 <= cyc;
         prev_pl0 <= last_pl0;
      end
      if (if0.ferr) fe_cnt0 <= fe_cnt0 + 1;
      if (if0.perr) pe_cnt0 <= pe_cnt0 + 1;
      if (if1.pl)   pl_cnt1 <= pl_cnt1 + 1;
      if (if1.ferr) fe_cnt1 <= fe_cnt1 + 1;
      if (if1.perr) pe_cnt1 <= pe_cnt1 + 1;
      if ((if0.pl & if0.ferr) | (if0.pl & if0.perr) | (if0.ferr & if0.perr) |
          (any0_q & (if0.pl | if0.ferr | if0.perr)) |
          (if1.pl & if1.ferr) | (if1.pl & if1.perr) | (if1.ferr & if1.perr) |
          (any1_q & (if1.pl | if1.ferr | if1.perr)))
         viol <= viol + 1;
      any0_q <= if0.pl | if0.ferr | if0.perr;
      any1_q <= if1.pl | if1.ferr | if1.perr;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] g_dout(input int d);
      return (d == 0) ? if0.dout : if1.dout;
   endfunction
   function automatic logic [2:0] g_strb(input int d);
      return (d == 0) ? {if0.pl, if0.ferr, if0.perr} : {if1.pl, if1.ferr, if1.perr};
   endfunction
   function automatic logic g_busy(input int d);
      return (d == 0) ? if0.busy : if1.busy;
   endfunction

   task automatic drive(input int d, input logic s, input logic b);
      if (d == 0) begin if0.sen = s; if0.sin = b; end
      else        begin if1.sen = s; if1.sin = b; end
   endtask

   // one sen sample followed by period-1 idle clocks
   task automatic sample(input int d, input logic b, input int period);
      drive(d, 1'b1, b);
      @(negedge clk);
      drive(d, 1'b0, 1'b1);
      if (period > 1) repeat (period - 1) @(negedge clk);
   endtask

   task automatic send_frame(input vec_t v);
      int pl0, fe0, pe0, pl1, fe1, pe1;
      #1;
      pl0 = (v.d == 0) ? pl_cnt0 : pl_cnt1;
      fe0 = (v.d == 0) ? fe_cnt0 : fe_cnt1;
      pe0 = (v.d == 0) ? pe_cnt0 : pe_cnt1;
      sample(v.d, 1'b0, v.period);
      for (int i = 7; i >= 0; i--) sample(v.d, v.bits[i], v.period);
`ifdef PARITY_EN
      sample(v.d, v.par, v.period);
`endif
      drive(v.d, 1'b1, v.stop);
      @(negedge clk);
      drive(v.d, 1'b0, 1'b1);
      chk({v.name, "_strobes"}, {29'd0, g_strb(v.d)}, {29'd0, v.exp_pl, v.exp_ferr, v.exp_perr});
      chk({v.name, "_dout"}, {24'd0, g_dout(v.d)}, {24'd0, v.exp_dout});
      @(negedge clk);
      chk({v.name, "_strobe_1cyc"}, {29'd0, g_strb(v.d)}, 32'd0);
      chk({v.name, "_busy_after"}, {31'd0, g_busy(v.d)}, 32'd0);
      chk({v.name, "_dout_hold"}, {24'd0, g_dout(v.d)}, {24'd0, v.exp_dout});
      if (v.period > 2) repeat (v.period - 2) @(negedge clk);
      #1;
      pl1 = (v.d == 0) ? pl_cnt0 : pl_cnt1;
      fe1 = (v.d == 0) ? fe_cnt0 : fe_cnt1;
      pe1 = (v.d == 0) ? pe_cnt0 : pe_cnt1;
      chk({v.name, "_pulse_counts"}, {pl1 - pl0, fe1 - fe0, pe1 - pe0},
          {32'(v.exp_pl), 32'(v.exp_ferr), 32'(v.exp_perr)});
   endtask

   vec_t vecs[$];

   initial begin
      // d, bits, par, stop, period, exp_dout, pl, ferr, perr, name
      vecs.push_back('{0, 8'hAF, 1'b0, 1'b1, 1, 8'hAF, 1'b1, 1'b0, 1'b0, "msb_af"});
      vecs.push_back('{1, 8'hAF, 1'b0, 1'b1, 4, 8'hF5, 1'b1, 1'b0, 1'b0, "lsb_af_sen4"});
      vecs.push_back('{0, 8'h3C, 1'b0, 1'b0, 1, 8'hAF, 1'b0, 1'b1, 1'b0, "msb_3c_ferr"});
      vecs.push_back('{1, 8'h3C, 1'b0, 1'b0, 2, 8'hF5, 1'b0, 1'b1, 1'b0, "lsb_3c_ferr"});
      vecs.push_back('{0, 8'h12, 1'b0, 1'b1, 1, 8'h12, 1'b1, 1'b0, 1'b0, "b2b_12"});
      vecs.push_back('{0, 8'h34, 1'b1, 1'b1, 1, 8'h34, 1'b1, 1'b0, 1'b0, "b2b_34"});
      vecs.push_back('{1, 8'h1E, 1'b0, 1'b1, 3, 8'h78, 1'b1, 1'b0, 1'b0, "lsb_1e"});
`ifdef PARITY_EN
      vecs.push_back('{0, 8'h01, 1'b0, 1'b1, 1, 8'h34, 1'b0, 1'b0, 1'b1, "par_bad_01"});
      vecs.push_back('{0, 8'h01, 1'b1, 1'b1, 1, 8'h01, 1'b1, 1'b0, 1'b0, "par_good_01"});
      vecs.push_back('{0, 8'h0F, 1'b1, 1'b0, 1, 8'h01, 1'b0, 1'b1, 1'b0, "ferr_over_perr"});
`endif

      rst = 1'b1;
      drive(0, 1'b0, 1'b1);
      drive(1, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      chk("reset_dout0", {24'd0, if0.dout}, 32'd0);
      chk("reset_dout1", {24'd0, if1.dout}, 32'd0);
      chk("reset_busy", {30'd0, if0.busy, if1.busy}, 32'd0);
      chk("reset_strobes", {26'd0, g_strb(0), g_strb(1)}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         send_frame(vecs[i]);
         if (vecs[i].name == "b2b_34")
            chk("b2b_pl_gap_ok", {31'd0, (last_pl0 - prev_pl0) >= FRAME_LEN}, 32'd1);
      end

      // partial frames, then an asynchronous reset in the middle of them
      sample(1, 1'b0, 4);
      chk("hold_busy_between_sen", {31'd0, if1.busy}, 32'd1);
      sample(0, 1'b0, 1);
      sample(0, 1'b0, 1);
      sample(0, 1'b1, 1);
      sample(0, 1'b0, 1);
      sample(0, 1'b1, 1);
      chk("partial_busy", {31'd0, if0.busy}, 32'd1);
      begin
         int s0;
         #1;
         s0 = pl_cnt0 + fe_cnt0 + pe_cnt0 + pl_cnt1 + fe_cnt1 + pe_cnt1;
         #1 rst = 1'b1;
         #1;
         chk("async_rst_busy", {30'd0, if0.busy, if1.busy}, 32'd0);
         chk("async_rst_dout0", {24'd0, if0.dout}, 32'd0);
         chk("async_rst_dout1", {24'd0, if1.dout}, 32'd0);
         repeat (2) @(negedge clk);
         rst = 1'b0;
         #1;
         chk("no_strobe_in_reset",
             pl_cnt0 + fe_cnt0 + pe_cnt0 + pl_cnt1 + fe_cnt1 + pe_cnt1 - s0, 32'd0);
      end
      @(negedge clk);
      send_frame('{0, 8'h5A, 1'b0, 1'b1, 1, 8'h5A, 1'b1, 1'b0, 1'b0, "post_rst_5a"});

      chk("strobe_rules", viol, 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
